// File: rtl/sigmoid_bwd_serial.sv
// Sigmoid backward pass: out_grad = grad * y * (1 - y), using one serial
// shift-add multiplier that is run twice per operand pair.
module sigmoid_bwd_serial #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_y,
   input  logic [DATA_W-1:0] in_grad,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_grad,
   output logic              out_clamp
);

   // state | meaning
   // IDLE  | waiting for an operand pair, in_ready=1
   // MUL1  | serial multiply d = (yc * (1 - yc)) >> FRAC_W
   // MUL2  | serial multiply |grad| * d, signed and scaled at the last step
   // DONE  | result presented until out_ready
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL1 = 2'd1;
   localparam logic [1:0] ST_MUL2 = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam int                PROD_W   = 2 * DATA_W;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] ONE      = DATA_W'(1) << FRAC_W;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] gabs_q, gabs_d;
   logic              grad_neg_q, grad_neg_d;
   logic              clamp_q, clamp_d;
   logic [DATA_W-1:0] out_grad_q, out_grad_d;
   logic              out_clamp_q, out_clamp_d;

   logic [DATA_W-1:0]        yc;
   logic                     y_clip;
   logic [PROD_W-1:0]        acc_sum;
   logic signed [PROD_W-1:0] prod_s;

   always_comb begin
      yc     = in_y;
      y_clip = 1'b0;
      if (in_y[DATA_W-1]) begin
         yc     = '0;
         y_clip = 1'b1;
      end else if (in_y > ONE) begin
         yc     = ONE;
         y_clip = 1'b1;
      end

      acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod_s  = grad_neg_q ? -$signed(acc_sum) : $signed(acc_sum);

      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      gabs_d      = gabs_q;
      grad_neg_d  = grad_neg_q;
      clamp_d     = clamp_q;
      out_grad_d  = out_grad_q;
      out_clamp_d = out_clamp_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d    = ST_MUL1;
               cnt_d      = '0;
               mcand_d    = {{DATA_W{1'b0}}, yc};
               mplier_d   = ONE - yc;
               acc_d      = '0;
               grad_neg_d = in_grad[DATA_W-1];
               gabs_d     = in_grad[DATA_W-1] ? -in_grad : in_grad;
               clamp_d    = y_clip;
            end
         end
         ST_MUL1: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // last partial product: reload the engine for |grad| * d
            if (cnt_q == CNT_LAST) begin
               state_d  = ST_MUL2;
               cnt_d    = '0;
               mcand_d  = {{DATA_W{1'b0}}, gabs_q};
               mplier_d = DATA_W'(acc_sum >> FRAC_W);
               acc_d    = '0;
            end
         end
         ST_MUL2: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               cnt_d       = '0;
               out_grad_d  = DATA_W'(prod_s >>> FRAC_W);
               out_clamp_d = clamp_q;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         gabs_q      <= '0;
         grad_neg_q  <= 1'b0;
         clamp_q     <= 1'b0;
         out_grad_q  <= '0;
         out_clamp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         gabs_q      <= gabs_d;
         grad_neg_q  <= grad_neg_d;
         clamp_q     <= clamp_d;
         out_grad_q  <= out_grad_d;
         out_clamp_q <= out_clamp_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_grad  = out_grad_q;
   assign out_clamp = out_clamp_q;

endmodule

// File: tb/tb_sigmoid_bwd_serial.sv
// Directed self-checking bench for sigmoid_bwd_serial.
module tb_sigmoid_bwd_serial;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_y = '0;
   logic [15:0] in_grad = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_grad;
   logic        out_clamp;

   int n_checks = 0;
   int n_fail   = 0;

   sigmoid_bwd_serial #(.DATA_W(16), .FRAC_W(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_y      (in_y),
      .in_grad   (in_grad),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_grad  (out_grad),
      .out_clamp (out_clamp)
   );

   always #5 clk = ~clk;

   // Drives one operand pair, returns edges from accept until out_valid (100 = timeout).
   task automatic send(input logic [15:0] y, input logic [15:0] g, output int lat);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_y     = y;
      in_grad  = g;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (out_grad !== 16'h0000) begin n_fail++; $display("FAIL reset_out_grad got=%h exp=0000", out_grad); end
      n_checks++; if (out_clamp !== 1'b0) begin n_fail++; $display("FAIL reset_out_clamp got=%b exp=0", out_clamp); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      logic [15:0] ty [7] = '{16'h0100, 16'h0080, 16'h0100, 16'h0100, 16'hFF00, 16'h0300, 16'h0200};
      logic [15:0] tg [7] = '{16'h0200, 16'h0400, 16'h8000, 16'hFFFF, 16'h0200, 16'h0200, 16'h0200};
      logic [15:0] eg [7] = '{16'h0080, 16'h00C0, 16'hE000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
      logic        ec [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(ty[i], tg[i], lat);
         n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL vec%0d_latency got=%0d exp=32", i, lat); end
         n_checks++; if (out_grad !== eg[i]) begin n_fail++; $display("FAIL vec%0d_out_grad got=%h exp=%h", i, out_grad, eg[i]); end
         n_checks++; if (out_clamp !== ec[i]) begin n_fail++; $display("FAIL vec%0d_out_clamp got=%b exp=%b", i, out_clamp, ec[i]); end
      end
      @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
      n_checks++; if (out_grad !== 16'h0000) begin n_fail++; $display("FAIL out_grad_hold got=%h exp=0000", out_grad); end
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      send(16'h0080, 16'h0400, lat);
      n_checks++; if (lat !== 32 || out_grad !== 16'h00C0) begin n_fail++; $display("FAIL bp_result got lat=%0d grad=%h exp lat=32 grad=00c0", lat, out_grad); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0);
         in_y     = 16'h0100;
         in_grad  = 16'h0200;
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_grad !== 16'h00C0 || out_clamp !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d got vld=%b rdy=%b grad=%h clamp=%b exp vld=1 rdy=0 grad=00c0 clamp=0", i, out_valid, in_ready, out_grad, out_clamp);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1 || out_grad !== 16'h00C0) begin n_fail++; $display("FAIL bp_no_accept got rdy=%b grad=%h exp rdy=1 grad=00c0", in_ready, out_grad); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] by [3] = '{16'h0100, 16'h0080, 16'h0100};
      logic [15:0] bg [3] = '{16'h0200, 16'h0400, 16'h8000};
      logic [15:0] be [3] = '{16'h0080, 16'h00C0, 16'hE000};
      int acc_cyc [3];
      int vld_cyc [4];
      logic [15:0] res [4];
      int cyc, idx, nres;
      logic rdy;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_y     = by[0];
      in_grad  = bg[0];
      cyc = 0; idx = 0; nres = 0;
      while (cyc < 160) begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (rdy && in_valid) begin
            if (idx < 3) acc_cyc[idx] = cyc;
            idx++;
            if (idx < 3) begin
               in_y    = by[idx];
               in_grad = bg[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            if (nres < 4) begin
               res[nres]     = out_grad;
               vld_cyc[nres] = cyc;
            end
            nres++;
         end
         @(negedge clk);
      end
      n_checks++; if (idx !== 3 || nres !== 3) begin n_fail++; $display("FAIL b2b_counts got accepts=%0d results=%0d exp 3 3", idx, nres); end
      for (int i = 0; i < 3; i++) begin
         if (i < nres) begin
            n_checks++; if (res[i] !== be[i]) begin n_fail++; $display("FAIL b2b_result%0d got=%h exp=%h", i, res[i], be[i]); end
            n_checks++; if (vld_cyc[i] - acc_cyc[i] !== 32) begin n_fail++; $display("FAIL b2b_latency%0d got=%0d exp=32", i, vld_cyc[i] - acc_cyc[i]); end
         end
         if (i > 0 && i < idx) begin
            n_checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 34) begin n_fail++; $display("FAIL b2b_spacing%0d got=%0d exp=34", i, acc_cyc[i] - acc_cyc[i-1]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      out_ready = 1'b1;
      send(16'h0100, 16'h8000, lat);
      n_checks++; if (out_grad !== 16'hE000) begin n_fail++; $display("FAIL rm_pre got=%h exp=e000", out_grad); end
      @(negedge clk);
      in_valid = 1'b1;
      in_y     = 16'hFF00;
      in_grad  = 16'h7FFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (23) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_grad !== 16'h0000 || out_clamp !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_async got rdy=%b vld=%b grad=%h clamp=%b exp rdy=1 vld=0 grad=0000 clamp=0", in_ready, out_valid, out_grad, out_clamp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h0080, 16'h0400, lat);
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL rm_latency got=%0d exp=32", lat); end
      n_checks++; if (out_grad !== 16'h00C0 || out_clamp !== 1'b0) begin n_fail++; $display("FAIL rm_after got grad=%h clamp=%b exp grad=00c0 clamp=0", out_grad, out_clamp); end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
